// File: rtl/tfa_pkg.sv
// Shared widths, address sizes and controller states
// for the matrix-vector scheduler and its dot-product unit.
package tfa_pkg;

    localparam int BIT_WIDTH  = 4;
    localparam int VEC_SIZE   = 64;
    localparam int MAX_ROWS   = 256;
    localparam int MAX_CHUNKS = 16;
    localparam int DATA_WIDTH = BIT_WIDTH * VEC_SIZE;
    localparam int ACC_WIDTH  = 2 * BIT_WIDTH + $clog2(VEC_SIZE);
    localparam int OUT_WIDTH  = ACC_WIDTH + $clog2(MAX_CHUNKS);
    localparam int ROW_W      = $clog2(MAX_ROWS);
    localparam int CHK_W      = $clog2(MAX_CHUNKS);
    localparam int WADDR_W    = ROW_W + CHK_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        OUT
    } state_e;

endpackage

// File: rtl/vec_product.sv
// Combinational signed dot product of two 64-lane
// vectors of 4-bit two's complement elements.
module vec_product
    import tfa_pkg::*;
(
    input  logic        [DATA_WIDTH-1:0] i_a,
    input  logic        [DATA_WIDTH-1:0] i_b,
    output logic signed [ACC_WIDTH-1:0]  o_dot
);

    logic signed [BIT_WIDTH-1:0]   a_el;
    logic signed [BIT_WIDTH-1:0]   b_el;
    logic signed [2*BIT_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   sum;

    always_comb begin
        a_el = '0;
        b_el = '0;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            a_el = i_a[i*BIT_WIDTH +: BIT_WIDTH];
            b_el = i_b[i*BIT_WIDTH +: BIT_WIDTH];
            prod = a_el * b_el;
            sum  = sum + ACC_WIDTH'(prod);
        end
        o_dot = sum;
    end

endmodule

// File: rtl/matvec_sched.sv
// Row-by-row matrix-vector scheduler: streams chunks into
// vec_product, accumulates per row, emits via valid/ready.
module matvec_sched
    import tfa_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ROW_W-1:0]      i_rows_m1,
    input  logic [CHK_W-1:0]      i_chunks_m1,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [WADDR_W-1:0]    o_w_addr,
    output logic [CHK_W-1:0]      o_x_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic [DATA_WIDTH-1:0] i_x_data,
    output logic                  o_out_valid,
    output logic [OUT_WIDTH-1:0]  o_out_data,
    output logic [ROW_W-1:0]      o_out_row,
    input  logic                  i_out_ready
);

    state_e state_q, state_d;
    logic [ROW_W-1:0]   rows_m1_q, rows_m1_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CHK_W-1:0]   chunks_m1_q, chunks_m1_d;
    logic [CHK_W-1:0]   chunk_q, chunk_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic               rvalid_q, first_q;
    logic               done_q, done_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] dot;
    logic               rd_en;

    vec_product u_vec_product (
        .i_a   (i_w_data),
        .i_b   (i_x_data),
        .o_dot (dot)
    );

    assign rd_en = (state_q == READ);

    always_comb begin
        state_d     = state_q;
        rows_m1_d   = rows_m1_q;
        chunks_m1_d = chunks_m1_q;
        row_d       = row_q;
        chunk_d     = chunk_q;
        waddr_d     = waddr_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = READ;
                    rows_m1_d   = i_rows_m1;
                    chunks_m1_d = i_chunks_m1;
                    row_d       = '0;
                    chunk_d     = '0;
                    waddr_d     = '0;
                end
            end
            READ: begin
                // Running address replaces row*(chunks)+chunk.
                waddr_d = waddr_q + 1'b1;
                if (chunk_q == chunks_m1_q) begin
                    chunk_d = '0;
                    state_d = DRAIN;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (i_out_ready) begin
                    if (row_q == rows_m1_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (rvalid_q) begin
            acc_d = (first_q ? '0 : acc_q) + OUT_WIDTH'(dot);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rows_m1_q   <= '0;
            chunks_m1_q <= '0;
            row_q       <= '0;
            chunk_q     <= '0;
            waddr_q     <= '0;
            rvalid_q    <= 1'b0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            rows_m1_q   <= rows_m1_d;
            chunks_m1_q <= chunks_m1_d;
            row_q       <= row_d;
            chunk_q     <= chunk_d;
            waddr_q     <= waddr_d;
            rvalid_q    <= rd_en;
            first_q     <= rd_en && (chunk_q == '0);
            done_q      <= done_d;
            acc_q       <= acc_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_rd_en     = rd_en;
    assign o_w_addr    = waddr_q;
    assign o_x_addr    = chunk_q;
    assign o_out_valid = (state_q == OUT);
    assign o_out_data  = acc_q;
    assign o_out_row   = row_q;

endmodule
